// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER alignment controller.
package ber_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam int NB_DELAY_DEF = 9;
    localparam int WINDOW_DEF   = 511;
    localparam int NB_WIN_DEF   = 9;
    localparam int NB_CNT_DEF   = 64;

    // Saturating increment of a counter that is 'width' bits wide (width <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value == max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/ber_align_ctrl_if.sv
// Port bundle of the BER alignment controller; BER_RELOCK_EN adds the relock counter.
interface ber_align_ctrl_if #(
    parameter int NB_DELAY = 9,
    parameter int NB_CNT   = 64
);
    logic                i_enable;
    logic                i_valid;
    logic                i_ref_bit;
    logic                i_rx_bit;
    logic                i_clear;
    logic [1:0]          o_state;
    logic                o_locked;
    logic [NB_DELAY-1:0] o_delay;
    logic [NB_CNT-1:0]   o_bit_cnt;
    logic [NB_CNT-1:0]   o_err_cnt;
    logic                o_ber_zero;
`ifdef BER_RELOCK_EN
    logic [15:0]         o_relock_cnt;
`endif

    modport master (
        output i_enable, i_valid, i_ref_bit, i_rx_bit, i_clear,
        input  o_state, o_locked, o_delay, o_bit_cnt, o_err_cnt, o_ber_zero
`ifdef BER_RELOCK_EN
        , input o_relock_cnt
`endif
    );

    modport slave (
        input  i_enable, i_valid, i_ref_bit, i_rx_bit, i_clear,
        output o_state, o_locked, o_delay, o_bit_cnt, o_err_cnt, o_ber_zero
`ifdef BER_RELOCK_EN
        , output o_relock_cnt
`endif
    );

endinterface

// File: rtl/ber_delay_line.sv
// Strobe-enabled reference delay line with a combinational tap select.
module ber_delay_line #(
    parameter int NB_DELAY = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                shift,
    input  logic                din,
    input  logic [NB_DELAY-1:0] sel,
    output logic                tap
);
    localparam int DEPTH = 1 << NB_DELAY;

    logic [DEPTH-1:0] shreg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (shift) begin
            shreg <= {shreg[DEPTH-2:0], din};
        end
    end

    // Tap d holds the reference bit from d+1 strobes ago.
    assign tap = shreg[sel];

endmodule

// File: rtl/ber_align_ctrl.sv
// BER alignment controller: sweeps reference delay, locks, then counts bits/errors.
// Optional macro BER_RELOCK_EN: windowed error monitor in LOCK with automatic re-search.
module ber_align_ctrl
    import ber_pkg::*;
#(
    parameter int NB_DELAY   = NB_DELAY_DEF,
    parameter int WINDOW     = WINDOW_DEF,
    parameter int NB_WIN     = NB_WIN_DEF,
    parameter int NB_CNT     = NB_CNT_DEF
`ifdef BER_RELOCK_EN
    , parameter int RELOCK_THR = 127
`endif
) (
    input logic             clock,
    input logic             reset,
    ber_align_ctrl_if.slave bus
);
    localparam logic [NB_DELAY-1:0] CAND_LAST = '1;
    localparam logic [NB_WIN-1:0]   WIN_LAST  = NB_WIN'(WINDOW - 1);
    localparam logic [NB_CNT-1:0]   CNT_MAX   = '1;
`ifdef BER_RELOCK_EN
    localparam logic [NB_WIN-1:0]   RELOCK_LIM = NB_WIN'(RELOCK_THR);
`endif

    state_t              state, state_n;
    logic [NB_DELAY-1:0] cand, cand_n, best_delay, best_delay_n, delay, delay_n, sel;
    logic [NB_WIN-1:0]   win_cnt, win_cnt_n, win_err, win_err_n, best_err, best_err_n;
    logic [NB_WIN-1:0]   win_err_sum;
    logic [NB_CNT-1:0]   bit_cnt, bit_cnt_n, err_cnt, err_cnt_n;
    logic                strobe, tap, mismatch, win_end, restart;
`ifdef BER_RELOCK_EN
    logic [15:0]         relock_cnt, relock_cnt_n;
`endif

    assign strobe = bus.i_enable & bus.i_valid;
    assign sel    = (state == LOCK) ? delay : cand;

    // A strobe coinciding with i_clear is discarded, including its reference bit.
    ber_delay_line #(.NB_DELAY(NB_DELAY)) u_delay_line (
        .clock (clock),
        .reset (reset),
        .shift (strobe & ~bus.i_clear),
        .din   (bus.i_ref_bit),
        .sel   (sel),
        .tap   (tap)
    );

    assign mismatch    = bus.i_rx_bit ^ tap;
    assign win_err_sum = win_err + NB_WIN'(mismatch);
    assign win_end     = strobe && (win_cnt == WIN_LAST);

    always_comb begin
        state_n      = state;
        cand_n       = cand;
        win_cnt_n    = win_cnt;
        win_err_n    = win_err;
        best_err_n   = best_err;
        best_delay_n = best_delay;
        delay_n      = delay;
        bit_cnt_n    = bit_cnt;
        err_cnt_n    = err_cnt;
        restart      = 1'b0;
`ifdef BER_RELOCK_EN
        relock_cnt_n = relock_cnt;
`endif
        if (bus.i_clear) begin
            state_n = SEARCH;
            restart = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_enable) begin
                        state_n = SEARCH;
                        restart = 1'b1;
                    end
                end
                SEARCH: begin
                    if (strobe && win_end) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                        bit_cnt_n = '0;
                        err_cnt_n = '0;
                        // Strict compare keeps the lowest delay on ties.
                        if (win_err_sum < best_err) begin
                            best_err_n   = win_err_sum;
                            best_delay_n = cand;
                        end
                        if (win_err_sum == '0) begin
                            state_n = LOCK;
                            delay_n = cand;
                        end else if (cand == CAND_LAST) begin
                            state_n = LOCK;
                            delay_n = (win_err_sum < best_err) ? cand : best_delay;
                        end else begin
                            cand_n = cand + 1'b1;
                        end
                    end else if (strobe) begin
                        win_cnt_n = win_cnt + 1'b1;
                        win_err_n = win_err_sum;
                    end
                end
                LOCK: begin
                    if (strobe && (bit_cnt != CNT_MAX)) begin
                        bit_cnt_n = NB_CNT'(sat_inc(64'(bit_cnt), NB_CNT));
                        if (mismatch) begin
                            err_cnt_n = NB_CNT'(sat_inc(64'(err_cnt), NB_CNT));
                        end
                    end
`ifdef BER_RELOCK_EN
                    if (strobe && win_end) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                        if (win_err_sum > RELOCK_LIM) begin
                            state_n      = SEARCH;
                            restart      = 1'b1;
                            relock_cnt_n = 16'(sat_inc(64'(relock_cnt), 16));
                        end
                    end else if (strobe) begin
                        win_cnt_n = win_cnt + 1'b1;
                        win_err_n = win_err_sum;
                    end
`endif
                end
                default: state_n = IDLE;
            endcase
        end
        if (restart) begin
            cand_n       = '0;
            win_cnt_n    = '0;
            win_err_n    = '0;
            best_err_n   = '1;
            best_delay_n = '0;
            delay_n      = '0;
            bit_cnt_n    = '0;
            err_cnt_n    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cand       <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
            best_err   <= '1;
            best_delay <= '0;
            delay      <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
`ifdef BER_RELOCK_EN
            relock_cnt <= '0;
`endif
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            win_cnt    <= win_cnt_n;
            win_err    <= win_err_n;
            best_err   <= best_err_n;
            best_delay <= best_delay_n;
            delay      <= delay_n;
            bit_cnt    <= bit_cnt_n;
            err_cnt    <= err_cnt_n;
`ifdef BER_RELOCK_EN
            relock_cnt <= relock_cnt_n;
`endif
        end
    end

    assign bus.o_state    = state;
    assign bus.o_locked   = (state == LOCK);
    assign bus.o_delay    = delay;
    assign bus.o_bit_cnt  = bit_cnt;
    assign bus.o_err_cnt  = err_cnt;
    assign bus.o_ber_zero = (state == LOCK) && (err_cnt == '0);
`ifdef BER_RELOCK_EN
    assign bus.o_relock_cnt = relock_cnt;
`endif

endmodule
